keccak_sponge: RTL and testbench
================================

KECCAK_SPONGE -- requirements
Module: keccak_sponge

Interface
REQ-001 Parameter OUT_WIDTH, default 256, digest width in bits; legal values 224, 256, 384, 512; RATE = 1600 - 2*OUT_WIDTH; R = RATE/64 words per block (18/17/13/9).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 in  input  64  message word; byte j occupies in[63-8j:56-8j].
REQ-005 in_ready  input  1  word valid.
REQ-006 is_last  input  1  final word; valid only with in_ready.
REQ-007 byte_num  input  3  valid bytes in the final word (0-7); ignored when is_last=0, which means 8 bytes.
REQ-008 buffer_full  output  1  word not accepted this cycle.
REQ-009 perm_start  output  1  one-cycle request to the external Keccak-f[1600] core.
REQ-010 perm_state_out  output  1600  sponge state; byte i at [1599-8i:1592-8i].
REQ-011 perm_state_in  input  1600  permuted state, same byte layout.
REQ-012 perm_done  input  1  one-cycle pulse; perm_state_in is valid.
REQ-013 out  output  OUT_WIDTH  digest equal to perm_state_out[1599:1600-OUT_WIDTH].
REQ-014 out_ready  output  1  digest valid.
REQ-015 out_ack  input  1  digest consumed; starts a new message.

Function
REQ-016 The FSM SHALL have three states:
- ABSORB: buffer_full=0.
- PERM: buffer_full=1.
- DONE: buffer_full=1, out_ready=1.
REQ-017 In ABSORB with in_ready=1, the word SHALL be XORed into state bytes 8*cnt..8*cnt+7, where cnt is the 0..R-1 word counter.
REQ-018 A non-last word with cnt=R-1 SHALL reset cnt to 0, set final=0 and go to PERM; otherwise cnt SHALL increment.
REQ-019 A last word with byte_num=m SHALL XOR only bytes 0..m-1.
- The domain byte D SHALL be XORed into byte 8*cnt+m.
- 0x80 SHALL be XORed into byte RATE/8-1, all in the same cycle.
- The FSM SHALL then set final=1, reset cnt and go to PERM.
REQ-020 When D and 0x80 land on the same byte (cnt=R-1, m=7), that byte SHALL equal D^0x80.
REQ-021 Padding SHALL always complete within the current block; no extra padding block exists.
REQ-022 perm_start SHALL pulse exactly once, in the first PERM cycle.
REQ-023 The state SHALL load from perm_state_in on the cycle perm_done is sampled. The next state is DONE if final=1, else ABSORB.
REQ-024 out_ready SHALL rise the cycle after perm_done. Latency from the last word accepted to out_ready = P+2 cycles, where P is the core latency from perm_start to perm_done.
REQ-025 out and out_ready SHALL stay stable in DONE until out_ack.
REQ-026 On out_ack in DONE, the state SHALL clear to 0, cnt and final SHALL clear, out_ready SHALL drop, and the FSM SHALL go to ABSORB on the next cycle.
REQ-027 The following SHALL be ignored:
- in_ready while buffer_full=1;
- perm_done outside PERM;
- out_ack outside DONE;
- is_last without in_ready.
REQ-028 in_ready and out_ack in the same DONE cycle SHALL honour only out_ack; the word SHALL not be absorbed.

Reset
REQ-029 When reset is low, the FSM SHALL go to ABSORB and the state, cnt, final, perm_start and out_ready SHALL clear to 0, regardless of the current state.
REQ-030 A perm_done arriving after reset is released SHALL be ignored per REQ-027.

Configuration
REQ-031 Macro KECCAK_SHA3_PAD_EN SHALL select the domain byte:
- defined: D=0x06 (FIPS-202 SHA-3);
- undefined: D=0x01 (original Keccak).

Verification
REQ-032 The bench SHALL use a behavioural Keccak-f model with P=24 and cover:
- OUT_WIDTH=256, KECCAK_SHA3_PAD_EN defined, single word is_last=1 byte_num=0 -> out=a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a; out_ready 26 cycles after acceptance.
- Same stimulus, macro undefined -> out=c5d2460186f7233c927e7db2dcc703c0e500b653ca82273b7bfad8045d85a470.
- OUT_WIDTH=256, macro defined, "abc" as in=0x6162630000000000, is_last=1, byte_num=3 -> out=3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- OUT_WIDTH=256, 17 full words then is_last=1 byte_num=0 -> exactly two perm_start pulses; buffer_full high from the 17th word until the first perm_done; result matches the model.
- Back-to-back: "abc" digest, out_ack, then the empty message -> second out equals the first-scenario value (state cleared).
- Reset low for one cycle during PERM, then a stray perm_done -> out_ready=0, no state load; a following "abc" yields the correct digest.

Source files
------------

// File: rtl/keccak_sponge.sv
// Keccak sponge controller: absorbs 64-bit words, pads, drives an external Keccak-f[1600] core, holds the digest.
// Define KECCAK_SHA3_PAD_EN to use the FIPS-202 SHA-3 domain byte 0x06; otherwise the original Keccak byte 0x01 is used.
module keccak_sponge #(
    parameter int OUT_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          in,
    input  logic                 in_ready,
    input  logic                 is_last,
    input  logic [2:0]           byte_num,
    output logic                 buffer_full,
    output logic                 perm_start,
    output logic [1599:0]        perm_state_out,
    input  logic [1599:0]        perm_state_in,
    input  logic                 perm_done,
    output logic [OUT_WIDTH-1:0] out,
    output logic                 out_ready,
    input  logic                 out_ack
);

    localparam int RATE   = 1600 - 2 * OUT_WIDTH;
    localparam int R      = RATE / 64;
    localparam int RB     = RATE / 8;
    localparam int PAD_HI = 1599 - 8 * (RB - 1);
    localparam logic [4:0] LAST_CNT = 5'(R - 1);

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0] DOMAIN = 8'h06;
`else
    localparam logic [7:0] DOMAIN = 8'h01;
`endif

    typedef enum logic [1:0] {
        ABSORB,
        PERM,
        DONE
    } state_e;

    state_e         fsm_q, fsm_d;
    logic [1599:0]  state_q, state_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           final_q, final_d;
    logic           perm_start_q, perm_start_d;
    logic           out_ready_q, out_ready_d;

    logic [63:0]    word;
    logic [1599:0]  word_ext;
    logic [1599:0]  absorb_mask;

    // Last word: keep the valid bytes, drop the domain byte right after them, and
    // fold the closing 0x80 into the last rate byte so padding never spills over.
    always_comb begin
        word = in;
        if (is_last) begin
            for (int unsigned j = 0; j < 8; j++) begin
                if (j >= 32'(byte_num)) begin
                    word[63 - 8 * j -: 8] = '0;
                end
            end
            word[63 - 8 * 32'(byte_num) -: 8] = DOMAIN;
        end
        word_ext = '0;
        word_ext[1599 -: 64] = word;
        absorb_mask = word_ext >> (64 * 32'(cnt_q));
        if (is_last) begin
            absorb_mask[PAD_HI -: 8] = absorb_mask[PAD_HI -: 8] ^ 8'h80;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        final_d      = final_q;
        perm_start_d = 1'b0;
        case (fsm_q)
            ABSORB: begin
                if (in_ready) begin
                    state_d = state_q ^ absorb_mask;
                    if (is_last) begin
                        final_d      = 1'b1;
                        cnt_d        = '0;
                        fsm_d        = PERM;
                        perm_start_d = 1'b1;
                    end else if (cnt_q == LAST_CNT) begin
                        final_d      = 1'b0;
                        cnt_d        = '0;
                        fsm_d        = PERM;
                        perm_start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            PERM: begin
                if (perm_done) begin
                    state_d = perm_state_in;
                    fsm_d   = final_q ? DONE : ABSORB;
                end
            end
            DONE: begin
                if (out_ack) begin
                    state_d = '0;
                    cnt_d   = '0;
                    final_d = 1'b0;
                    fsm_d   = ABSORB;
                end
            end
            default: fsm_d = ABSORB;
        endcase
        out_ready_d = (fsm_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q        <= ABSORB;
            state_q      <= '0;
            cnt_q        <= '0;
            final_q      <= 1'b0;
            perm_start_q <= 1'b0;
            out_ready_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            final_q      <= final_d;
            perm_start_q <= perm_start_d;
            out_ready_q  <= out_ready_d;
        end
    end

    assign buffer_full    = (fsm_q != ABSORB);
    assign perm_start     = perm_start_q;
    assign perm_state_out = state_q;
    assign out            = state_q[1599 -: OUT_WIDTH];
    assign out_ready      = out_ready_q;

endmodule

// File: tb/tb_keccak_sponge.sv
// Randomized bench for keccak_sponge (OUT_WIDTH=256) with a byte-level sponge model and a behavioural Keccak-f core (P=24).
module tb_keccak_sponge;

    localparam int OW = 256;
    localparam int RB = (1600 - 2 * OW) / 8;
    localparam int P  = 24;

`ifdef KECCAK_SHA3_PAD_EN
    localparam logic [7:0]   DOM        = 8'h06;
    localparam logic [255:0] EMPTY_HASH = 256'ha7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a;
    localparam logic [255:0] ABC_HASH   = 256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;
`else
    localparam logic [7:0]   DOM        = 8'h01;
    localparam logic [255:0] EMPTY_HASH = 256'hc5d2460186f7233c927e7db2dcc703c0e500b653ca82273b7bfad8045d85a470;
    localparam logic [255:0] ABC_HASH   = 256'h4e03657aea45a94fc7d47ba826c8d667c0d1e6e33a64a036ec44f58fa12d6c45;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [63:0]   d_in;
    logic          d_in_ready;
    logic          d_is_last;
    logic [2:0]    d_byte_num;
    logic          buffer_full;
    logic          perm_start;
    logic [1599:0] perm_state_out;
    logic [1599:0] perm_state_in;
    logic          perm_done;
    logic [OW-1:0] d_out;
    logic          out_ready;
    logic          d_out_ack;

    int            n_vec = 0;
    int            n_err = 0;
    int            nstart = 0;
    logic          core_busy;
    logic [7:0]    msg_q[$];

    keccak_sponge #(.OUT_WIDTH(OW)) dut (
        .clk            (clk),
        .reset          (reset),
        .in             (d_in),
        .in_ready       (d_in_ready),
        .is_last        (d_is_last),
        .byte_num       (d_byte_num),
        .buffer_full    (buffer_full),
        .perm_start     (perm_start),
        .perm_state_out (perm_state_out),
        .perm_state_in  (perm_state_in),
        .perm_done      (perm_done),
        .out            (d_out),
        .out_ready      (out_ready),
        .out_ack        (d_out_ack)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (perm_start) nstart++;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- Keccak-f[1600] reference (FIPS-202 step mappings) ----------------
    function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
        if (n == 0) return x;
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic rc_bit(input int t);
        int r;
        r = 1;
        for (int i = 1; i <= t % 255; i++) begin
            r = r << 1;
            if (r[8]) r = r ^ 32'h171;
        end
        return r[0];
    endfunction

    function automatic logic [1599:0] keccak_f(input logic [1599:0] s);
        logic [63:0]   a[25];
        logic [63:0]   b[25];
        logic [63:0]   c[5];
        logic [63:0]   dd;
        logic [63:0]   rcv;
        logic [1599:0] res;
        int            x, y, tmp;
        for (int l = 0; l < 25; l++)
            for (int k = 0; k < 8; k++)
                a[l][8*k +: 8] = s[1599 - 8*(8*l + k) -: 8];
        for (int ir = 0; ir < 24; ir++) begin
            for (int i = 0; i < 5; i++) c[i] = a[i] ^ a[i+5] ^ a[i+10] ^ a[i+15] ^ a[i+20];
            for (int i = 0; i < 5; i++) begin
                dd = c[(i + 4) % 5] ^ rotl(c[(i + 1) % 5], 1);
                for (int j = 0; j < 5; j++) a[i + 5*j] = a[i + 5*j] ^ dd;
            end
            x = 1; y = 0;
            for (int t = 0; t < 24; t++) begin
                a[x + 5*y] = rotl(a[x + 5*y], ((t + 1) * (t + 2) / 2) % 64);
                tmp = y;
                y = (2*x + 3*y) % 5;
                x = tmp;
            end
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    b[i + 5*j] = a[((i + 3*j) % 5) + 5*i];
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    a[i + 5*j] = b[i + 5*j] ^ (~b[((i + 1) % 5) + 5*j] & b[((i + 2) % 5) + 5*j]);
            rcv = '0;
            for (int j = 0; j < 7; j++) rcv[(1 << j) - 1] = rc_bit(j + 7*ir);
            a[0] = a[0] ^ rcv;
        end
        res = '0;
        for (int l = 0; l < 25; l++)
            for (int k = 0; k < 8; k++)
                res[1599 - 8*(8*l + k) -: 8] = a[l][8*k +: 8];
        return res;
    endfunction

    // Byte-level sponge: msg || D || 0* with 0x80 folded into the last byte of the block.
    function automatic logic [255:0] model_digest();
        logic [7:0]    p[$];
        logic [1599:0] s;
        p = msg_q;
        p.push_back(DOM);
        while (p.size() % RB != 0) p.push_back(8'h00);
        p[p.size() - 1] = p[p.size() - 1] ^ 8'h80;
        s = '0;
        for (int blk = 0; blk < p.size() / RB; blk++) begin
            for (int i = 0; i < RB; i++) s[1599 - 8*i -: 8] = s[1599 - 8*i -: 8] ^ p[blk*RB + i];
            s = keccak_f(s);
        end
        return s[1599 -: 256];
    endfunction

    // Behavioural permutation core: perm_done arrives P cycles after perm_start.
    initial begin
        logic [1599:0] nxt;
        perm_done     = 1'b0;
        perm_state_in = '0;
        core_busy     = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (perm_start) begin
                core_busy = 1'b1;
                nxt = keccak_f(perm_state_out);
                repeat (P) @(posedge clk);
                #1;
                perm_state_in = nxt;
                perm_done     = 1'b1;
                @(posedge clk); #1;
                perm_done     = 1'b0;
                perm_state_in = {50{$urandom}};
                core_busy     = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            d_in_ready = 1'b0;
            d_is_last  = 1'($urandom);
            d_out_ack  = 1'($urandom);
            d_in       = {$urandom, $urandom};
            @(posedge clk); #1;
        end
        d_out_ack = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] w, input logic last, input logic [2:0] m, output int waits);
        d_in       = w;
        d_in_ready = 1'b1;
        d_is_last  = last;
        d_byte_num = m;
        waits      = 0;
        while (buffer_full && waits < 200) begin
            @(posedge clk); #1;
            waits++;
        end
        if (waits >= 200) check_eq("accept", 256'(buffer_full), 256'd0);
        @(posedge clk); #1;
        d_in_ready = 1'b0;
        d_is_last  = 1'($urandom);
        d_in       = {$urandom, $urandom};
    endtask

    task automatic send_msg(input logic gaps, input logic zero_pad, output int last_waits);
        int          nfull, m, wt;
        logic [63:0] w;
        nfull = msg_q.size() / 8;
        m     = msg_q.size() % 8;
        for (int wi = 0; wi < nfull; wi++) begin
            for (int j = 0; j < 8; j++) w[63 - 8*j -: 8] = msg_q[8*wi + j];
            if (gaps) idle($urandom_range(0, 2));
            send_word(w, 1'b0, 3'($urandom), wt);
        end
        w = zero_pad ? 64'd0 : {$urandom, $urandom};
        for (int j = 0; j < m; j++) w[63 - 8*j -: 8] = msg_q[8*nfull + j];
        if (gaps) idle($urandom_range(0, 2));
        send_word(w, 1'b1, 3'(m), last_waits);
    endtask

    task automatic get_digest(input logic [255:0] exp, input string tag);
        int lat;
        lat = 1;
        while (!out_ready && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 256'(lat), 256'(P + 2));
        check_eq({tag, "_out"}, d_out, exp);
        repeat ($urandom_range(1, 3)) begin
            d_in_ready = 1'($urandom);
            d_in       = {$urandom, $urandom};
            @(posedge clk); #1;
            check_eq({tag, "_hold_out"}, d_out, exp);
            check_eq({tag, "_hold_rdy"}, 256'(out_ready), 256'd1);
        end
        d_out_ack  = 1'b1;
        d_in_ready = 1'b1;
        d_in       = {$urandom, $urandom};
        d_is_last  = 1'($urandom);
        @(posedge clk); #1;
        d_out_ack  = 1'b0;
        d_in_ready = 1'b0;
        check_eq({tag, "_ack_rdy"}, 256'(out_ready), 256'd0);
        check_eq({tag, "_ack_clr"}, 256'(|perm_state_out), 256'd0);
        check_eq({tag, "_ack_bf"}, 256'(buffer_full), 256'd0);
    endtask

    task automatic fill_rand(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wt, s0, n;
        int lens[11];
        d_in = '0; d_in_ready = 1'b0; d_is_last = 1'b0; d_byte_num = '0; d_out_ack = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rdy",   256'(out_ready), 256'd0);
        check_eq("rst_bf",    256'(buffer_full), 256'd0);
        check_eq("rst_start", 256'(perm_start), 256'd0);
        check_eq("rst_state", 256'(|perm_state_out), 256'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        msg_q.delete();
        send_msg(1'b0, 1'b1, wt);
        get_digest(EMPTY_HASH, "empty");

        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, 1'b1, wt);
        get_digest(ABC_HASH, "abc");

        msg_q.delete();
        send_msg(1'b0, 1'b1, wt);
        get_digest(EMPTY_HASH, "b2b_empty");

        // 17 full words fill one block; the empty last word pads a second block.
        fill_rand(136);
        s0 = nstart;
        send_msg(1'b0, 1'b0, wt);
        check_eq("long_bf_cycles", 256'(wt), 256'(P + 1));
        get_digest(model_digest(), "long");
        check_eq("long_starts", 256'(nstart - s0), 256'd2);

        lens = '{135, 0, 7, 8, 143, 271, 272, 1, 0, 0, 0};
        for (int i = 8; i < 11; i++) lens[i] = $urandom_range(2, 300);
        foreach (lens[i]) begin
            fill_rand(lens[i]);
            send_msg(1'b1, 1'b0, wt);
            get_digest(model_digest(), "rand");
        end

        // Reset mid-permutation; the core's late perm_done must then be ignored.
        fill_rand(5);
        send_msg(1'b0, 1'b0, wt);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("perm_rst_rdy",   256'(out_ready), 256'd0);
        check_eq("perm_rst_bf",    256'(buffer_full), 256'd0);
        check_eq("perm_rst_state", 256'(|perm_state_out), 256'd0);
        reset = 1'b1;
        n = 0;
        while (core_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        check_eq("stray_rdy",   256'(out_ready), 256'd0);
        check_eq("stray_bf",    256'(buffer_full), 256'd0);
        check_eq("stray_state", 256'(|perm_state_out), 256'd0);

        msg_q = '{8'h61, 8'h62, 8'h63};
        send_msg(1'b0, 1'b1, wt);
        get_digest(ABC_HASH, "abc_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
